// File: rtl/rob_if.sv
// Handshake/bus bundle between dispatch, RAT, writeback bus, ARF commit port and the reorder buffer.
interface rob_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int ARCH_W = 2
);
   localparam int TW = $clog2(DEPTH);

   logic              i_flush;
   logic              i_alloc_valid;
   logic [ARCH_W-1:0] i_alloc_dst;
   logic              o_alloc_ready;
   logic              o_rat_valid;
   logic [TW-1:0]     o_rat_rob_addr;
   logic [ARCH_W-1:0] o_rat_dst_addr;
   logic              i_wb_valid;
   logic [TW-1:0]     i_wb_tag;
   logic [DATA_W-1:0] i_wb_data;
   logic              i_commit_ready;
   logic              o_commit_valid;
   logic [TW-1:0]     o_commit_tag;
   logic [ARCH_W-1:0] o_commit_dst;
   logic [DATA_W-1:0] o_commit_data;
   logic [TW:0]       o_count;
   logic              o_full;
   logic              o_empty;

   modport slave (
      input  i_flush, i_alloc_valid, i_alloc_dst, i_wb_valid, i_wb_tag, i_wb_data, i_commit_ready,
      output o_alloc_ready, o_rat_valid, o_rat_rob_addr, o_rat_dst_addr,
             o_commit_valid, o_commit_tag, o_commit_dst, o_commit_data,
             o_count, o_full, o_empty
   );

   modport master (
      output i_flush, i_alloc_valid, i_alloc_dst, i_wb_valid, i_wb_tag, i_wb_data, i_commit_ready,
      input  o_alloc_ready, o_rat_valid, o_rat_rob_addr, o_rat_dst_addr,
             o_commit_valid, o_commit_tag, o_commit_dst, o_commit_data,
             o_count, o_full, o_empty
   );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire with out-of-order writeback capture.
// Optional ROB_WB_BYPASS_EN lets a head-entry writeback retire in the same cycle.
module rob #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int ARCH_W = 2
) (
   input logic i_clk,
   input logic i_rstn,
   rob_if.slave bus
);
   localparam int TW = $clog2(DEPTH);

   logic [TW:0]       head, tail, count;
   logic [TW-1:0]     head_idx, tail_idx;
   logic [DEPTH-1:0]  vld, done;
   logic [ARCH_W-1:0] dst_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic              full, alloc_fire, commit_fire, wb_ok, byp_hit;

   assign head_idx = head[TW-1:0];
   assign tail_idx = tail[TW-1:0];
   // Wrap bit makes tail-head an exact occupancy in 0..DEPTH.
   assign count    = tail - head;
   assign full     = (head_idx == tail_idx) && (head[TW] != tail[TW]);

   assign alloc_fire = bus.i_alloc_valid & ~full & ~bus.i_flush;
   assign wb_ok      = bus.i_wb_valid & vld[bus.i_wb_tag] & ~done[bus.i_wb_tag] & ~bus.i_flush;

`ifdef ROB_WB_BYPASS_EN
   assign byp_hit = vld[head_idx] & ~done[head_idx] & bus.i_wb_valid & (bus.i_wb_tag == head_idx);
`else
   assign byp_hit = 1'b0;
`endif

   assign bus.o_commit_valid = vld[head_idx] & (done[head_idx] | byp_hit) & ~bus.i_flush;
   assign commit_fire        = bus.o_commit_valid & bus.i_commit_ready;
   assign bus.o_commit_tag   = head_idx;
   assign bus.o_commit_dst   = dst_q[head_idx];
   assign bus.o_commit_data  = byp_hit ? bus.i_wb_data : data_q[head_idx];

   assign bus.o_alloc_ready  = ~full;
   assign bus.o_rat_valid    = alloc_fire;
   assign bus.o_rat_rob_addr = tail_idx;
   assign bus.o_rat_dst_addr = bus.i_alloc_dst;
   assign bus.o_count        = count;
   assign bus.o_full         = full;
   assign bus.o_empty        = (count == '0);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         head <= '0;
         tail <= '0;
         vld  <= '0;
         done <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (bus.i_flush) begin
         head <= '0;
         tail <= '0;
         vld  <= '0;
         done <= '0;
      end else begin
         if (wb_ok) begin
            done[bus.i_wb_tag]   <= 1'b1;
            data_q[bus.i_wb_tag] <= bus.i_wb_data;
         end
         if (alloc_fire) begin
            vld[tail_idx]    <= 1'b1;
            done[tail_idx]   <= 1'b0;
            dst_q[tail_idx]  <= bus.i_alloc_dst;
            data_q[tail_idx] <= '0;
            tail             <= tail + 1'b1;
         end
         // Retire last so a bypassed head writeback is cleared along with the entry.
         if (commit_fire) begin
            vld[head_idx]  <= 1'b0;
            done[head_idx] <= 1'b0;
            head           <= head + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob: allocate, writeback, in-order commit, wrap, flush, reset.
module tb_rob;
   logic i_clk = 1'b0;
   logic i_rstn;
   int   passed = 0;
   int   total  = 0;
   int   failed = 0;

   rob_if #(.DEPTH(4), .DATA_W(16), .ARCH_W(2)) bus ();

   rob #(.DEPTH(4), .DATA_W(16), .ARCH_W(2)) dut (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .bus    (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rstn             = 1'b0;
      bus.i_flush        = 1'b0;
      bus.i_alloc_valid  = 1'b0;
      bus.i_alloc_dst    = '0;
      bus.i_wb_valid     = 1'b0;
      bus.i_wb_tag       = '0;
      bus.i_wb_data      = '0;
      bus.i_commit_ready = 1'b0;
      #12;
      chk("rst_empty",    32'(bus.o_empty), 1);
      chk("rst_ready",    32'(bus.o_alloc_ready), 1);
      chk("rst_count",    32'(bus.o_count), 0);
      chk("rst_full",     32'(bus.o_full), 0);
      chk("rst_cvalid",   32'(bus.o_commit_valid), 0);
      chk("rst_ratv",     32'(bus.o_rat_valid), 0);
      chk("rst_cdata",    32'(bus.o_commit_data), 0);
      chk("rst_ctag",     32'(bus.o_commit_tag), 0);
      i_rstn = 1'b1;
      tick();

      // First allocate
      bus.i_alloc_valid = 1'b1;
      bus.i_alloc_dst   = 2'd2;
      #1;
      chk("a0_ratv",  32'(bus.o_rat_valid), 1);
      chk("a0_tag",   32'(bus.o_rat_rob_addr), 0);
      chk("a0_dst",   32'(bus.o_rat_dst_addr), 2);
      tick();
      bus.i_alloc_valid = 1'b0;
      #1;
      chk("a0_count", 32'(bus.o_count), 1);

      // Asynchronous reset mid-operation
      i_rstn = 1'b0;
      #1;
      chk("arst_count", 32'(bus.o_count), 0);
      chk("arst_empty", 32'(bus.o_empty), 1);
      i_rstn = 1'b1;
      tick();

      // Fill with dst 0..3
      for (int i = 0; i < 4; i++) begin
         bus.i_alloc_valid = 1'b1;
         bus.i_alloc_dst   = 2'(i);
         #1;
         chk($sformatf("fill%0d_tag", i), 32'(bus.o_rat_rob_addr), 32'(i));
         chk($sformatf("fill%0d_ratv", i), 32'(bus.o_rat_valid), 1);
         tick();
      end
      chk("full_full",  32'(bus.o_full), 1);
      chk("full_ready", 32'(bus.o_alloc_ready), 0);
      chk("full_count", 32'(bus.o_count), 4);
      bus.i_alloc_dst = 2'd1;
      #1;
      chk("full_ratv",  32'(bus.o_rat_valid), 0);
      tick();
      bus.i_alloc_valid = 1'b0;
      chk("full_count2", 32'(bus.o_count), 4);

      // Out-of-order writebacks: tag 2 then tag 0
      bus.i_wb_valid = 1'b1;
      bus.i_wb_tag   = 2'd2;
      bus.i_wb_data  = 16'h0006;
      #1;
      chk("wb2_cvalid", 32'(bus.o_commit_valid), 0);
      tick();
      bus.i_wb_tag  = 2'd0;
      bus.i_wb_data = 16'h0005;
      tick();
      bus.i_wb_valid = 1'b0;
      #1;
      chk("c0_valid", 32'(bus.o_commit_valid), 1);
      chk("c0_tag",   32'(bus.o_commit_tag), 0);
      chk("c0_dst",   32'(bus.o_commit_dst), 0);
      chk("c0_data",  32'(bus.o_commit_data), 32'h5);

      // Full + commit + alloc in the same cycle: alloc refused
      bus.i_commit_ready = 1'b1;
      bus.i_alloc_valid  = 1'b1;
      bus.i_alloc_dst    = 2'd3;
      #1;
      chk("fc_cvalid", 32'(bus.o_commit_valid), 1);
      chk("fc_ratv",   32'(bus.o_rat_valid), 0);
      tick();
      chk("fc_count",  32'(bus.o_count), 3);
      chk("h1_cvalid", 32'(bus.o_commit_valid), 0);
      chk("wrap_ratv", 32'(bus.o_rat_valid), 1);
      chk("wrap_tag",  32'(bus.o_rat_rob_addr), 0);
      tick();
      bus.i_alloc_valid  = 1'b0;
      bus.i_commit_ready = 1'b0;
      chk("wrap_count", 32'(bus.o_count), 4);
      chk("wrap_full",  32'(bus.o_full), 1);

      // Writeback to an already-done entry is ignored
      bus.i_wb_valid = 1'b1;
      bus.i_wb_tag   = 2'd2;
      bus.i_wb_data  = 16'h00AA;
      tick();

      // Head tag 1 pending, writeback arrives with commit ready
      bus.i_wb_tag       = 2'd1;
      bus.i_wb_data      = 16'h0009;
      bus.i_commit_ready = 1'b1;
      #1;
`ifdef ROB_WB_BYPASS_EN
      chk("byp_cvalid", 32'(bus.o_commit_valid), 1);
      chk("byp_cdata",  32'(bus.o_commit_data), 32'h9);
      tick();
      bus.i_wb_valid = 1'b0;
`else
      chk("byp_cvalid", 32'(bus.o_commit_valid), 0);
      tick();
      bus.i_wb_valid = 1'b0;
      #1;
      chk("c1_valid", 32'(bus.o_commit_valid), 1);
      chk("c1_tag",   32'(bus.o_commit_tag), 1);
      chk("c1_dst",   32'(bus.o_commit_dst), 1);
      chk("c1_data",  32'(bus.o_commit_data), 32'h9);
      tick();
`endif
      #1;
      chk("c2_valid", 32'(bus.o_commit_valid), 1);
      chk("c2_tag",   32'(bus.o_commit_tag), 2);
      chk("c2_dst",   32'(bus.o_commit_dst), 2);
      chk("c2_data",  32'(bus.o_commit_data), 32'h6);
      tick();
      chk("c3_valid", 32'(bus.o_commit_valid), 0);
      chk("c3_count", 32'(bus.o_count), 2);
      bus.i_commit_ready = 1'b0;

      // Third outstanding entry, then flush with alloc and writeback asserted
      bus.i_alloc_valid = 1'b1;
      bus.i_alloc_dst   = 2'd0;
      #1;
      chk("a5_tag", 32'(bus.o_rat_rob_addr), 1);
      tick();
      chk("a5_count", 32'(bus.o_count), 3);
      bus.i_flush    = 1'b1;
      bus.i_wb_valid = 1'b1;
      bus.i_wb_tag   = 2'd3;
      bus.i_wb_data  = 16'h0011;
      #1;
      chk("fl_ratv",   32'(bus.o_rat_valid), 0);
      chk("fl_cvalid", 32'(bus.o_commit_valid), 0);
      tick();
      bus.i_flush       = 1'b0;
      bus.i_wb_valid    = 1'b0;
      bus.i_alloc_valid = 1'b0;
      #1;
      chk("fl_count", 32'(bus.o_count), 0);
      chk("fl_empty", 32'(bus.o_empty), 1);
      chk("fl_ctag",  32'(bus.o_commit_tag), 0);

      // After flush: tag 0 again; writeback to the entry being allocated is ignored
      bus.i_alloc_valid = 1'b1;
      bus.i_alloc_dst   = 2'd1;
      #1;
      chk("pf_tag0", 32'(bus.o_rat_rob_addr), 0);
      tick();
      bus.i_alloc_dst = 2'd2;
      bus.i_wb_valid  = 1'b1;
      bus.i_wb_tag    = 2'd1;
      bus.i_wb_data   = 16'h0033;
      #1;
      chk("pf_tag1", 32'(bus.o_rat_rob_addr), 1);
      tick();
      bus.i_alloc_valid = 1'b0;
      bus.i_wb_tag      = 2'd0;
      bus.i_wb_data     = 16'h0022;
      tick();
      bus.i_wb_valid = 1'b0;
      #1;
      chk("pf_cvalid", 32'(bus.o_commit_valid), 1);
      chk("pf_cdst",   32'(bus.o_commit_dst), 1);
      chk("pf_cdata",  32'(bus.o_commit_data), 32'h22);
      bus.i_commit_ready = 1'b1;
      tick();
      bus.i_commit_ready = 1'b0;
      #1;
      chk("pf_h1_cvalid", 32'(bus.o_commit_valid), 0);
      chk("pf_count",     32'(bus.o_count), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
